// File: rtl/kabeta_eic_pkg.sv
// Shared definitions for the Kabeta external interrupt controller:
// register offsets, per-source mode encoding, GIE bit position, source
// count, and the fixed-priority helper used to pick the winning source.
package kabeta_eic_pkg;

  localparam int EIC_NUM_SRC = 2;

  localparam logic [2:0] EIC_REG_PEND = 3'd0;
  localparam logic [2:0] EIC_REG_EN   = 3'd1;
  localparam logic [2:0] EIC_REG_CLR  = 3'd2;
  localparam logic [2:0] EIC_REG_MODE = 3'd3;
  localparam logic [2:0] EIC_REG_SET  = 3'd4;

  localparam logic EIC_MODE_EDGE  = 1'b0;
  localparam logic EIC_MODE_LEVEL = 1'b1;

  localparam int EIC_GIE_BIT = 31;

  // Source 0 wins; ID is 1 only when source 1 is the sole active source.
  function automatic logic eic_prio_id(input logic [EIC_NUM_SRC-1:0] eff);
    return ~eff[0] & eff[1];
  endfunction

endpackage

// File: rtl/irq_synchronizer.sv
// Two-flop synchronizer plus delay flop for one asynchronous interrupt line.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   irq_async raw device line
//   level     synchronized level (s2)
//   rise      one-cycle rising-edge pulse (s2 & ~d)
module irq_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_async,
  output logic level,
  output logic rise
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;
  logic d_d,  d_q;

  always_comb begin
    s1_d = irq_async;
    s2_d = s1_q;
    d_d  = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      d_q  <= d_d;
    end
  end

  assign level = s2_q;
  // d clears on reset, so a line already high at release counts as an edge.
  assign rise  = s2_q & ~d_q;

endmodule

// File: rtl/external_interrupt_controller.sv
// Memory-mapped external interrupt controller in front of the Kabeta core.
// Ports:
//   Sys_Clock, Sys_Reset  clock and asynchronous active-low reset
//   IRQ_In[1:0]           asynchronous device lines (bit 0 highest priority)
//   IO_EnR, IO_EnW        IO read/write strobes
//   IO_Address[29:0]      IO word address
//   IO_DataW[31:0]        write data
//   IO_DataR[31:0]        registered read data (0 when not hit)
//   EIC_I_Req, EIC_I_Id   registered request and winning source ID
module external_interrupt_controller
  import kabeta_eic_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR = 30'h3FFF_FF00
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic [1:0]  IRQ_In,
  input  logic        IO_EnR,
  input  logic        IO_EnW,
  input  logic [29:0] IO_Address,
  input  logic [31:0] IO_DataW,
  output logic [31:0] IO_DataR,
  output logic        EIC_I_Req,
  output logic        EIC_I_Id
);

  logic [EIC_NUM_SRC-1:0] lvl;
  logic [EIC_NUM_SRC-1:0] rise;

  for (genvar g = 0; g < EIC_NUM_SRC; g++) begin : g_sync
    irq_synchronizer u_sync (
      .clk       (Sys_Clock),
      .rst_n     (Sys_Reset),
      .irq_async (IRQ_In[g]),
      .level     (lvl[g]),
      .rise      (rise[g])
    );
  end

  logic [EIC_NUM_SRC-1:0] pend_d, pend_q;
  logic [EIC_NUM_SRC-1:0] en_d,   en_q;
  logic [EIC_NUM_SRC-1:0] mode_d, mode_q;
  logic                   gie_d,  gie_q;
  logic                   req_d,  req_q;
  logic                   id_d,   id_q;
  logic [31:0]            rdat_d, rdat_q;

  logic                   hit, wr, rd;
  logic [2:0]             off;
  logic [EIC_NUM_SRC-1:0] set_v, clr_v, eff;
  logic                   unused_dataw;

  assign hit = (IO_Address[29:3] == BASE_ADDR[29:3]);
  assign off = IO_Address[2:0];
  assign wr  = IO_EnW & hit;
  assign rd  = IO_EnR & hit;
  assign unused_dataw = ^IO_DataW[30:EIC_NUM_SRC];

  always_comb begin
    set_v  = (wr && off == EIC_REG_SET) ? IO_DataW[EIC_NUM_SRC-1:0] : '0;
    clr_v  = (wr && off == EIC_REG_CLR) ? IO_DataW[EIC_NUM_SRC-1:0] : '0;
    pend_d = pend_q;
    for (int i = 0; i < EIC_NUM_SRC; i++) begin
      if (mode_q[i] == EIC_MODE_LEVEL) begin
        pend_d[i] = lvl[i];
      end else if (rise[i] || set_v[i]) begin
        // Set wins over a simultaneous clear.
        pend_d[i] = 1'b1;
      end else if (clr_v[i]) begin
        pend_d[i] = 1'b0;
      end
    end

    en_d   = en_q;
    gie_d  = gie_q;
    mode_d = mode_q;
    if (wr && off == EIC_REG_EN) begin
      en_d  = IO_DataW[EIC_NUM_SRC-1:0];
      gie_d = IO_DataW[EIC_GIE_BIT];
    end
    if (wr && off == EIC_REG_MODE) begin
      mode_d = IO_DataW[EIC_NUM_SRC-1:0];
    end

    // Request is driven from registered state, so a register write lands
    // on the outputs one edge later.
    eff   = pend_q & en_q & {EIC_NUM_SRC{gie_q}};
    req_d = |eff;
    id_d  = eic_prio_id(eff);

    // Read returns pre-edge contents, including on a same-cycle write.
    rdat_d = '0;
    if (rd) begin
      case (off)
        EIC_REG_PEND: rdat_d[EIC_NUM_SRC-1:0] = pend_q;
        EIC_REG_EN: begin
          rdat_d[EIC_NUM_SRC-1:0] = en_q;
          rdat_d[EIC_GIE_BIT]     = gie_q;
        end
        EIC_REG_MODE: rdat_d[EIC_NUM_SRC-1:0] = mode_q;
        default:      rdat_d = '0;
      endcase
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      gie_q  <= 1'b0;
      req_q  <= 1'b0;
      id_q   <= 1'b0;
      rdat_q <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      gie_q  <= gie_d;
      req_q  <= req_d;
      id_q   <= id_d;
      rdat_q <= rdat_d;
    end
  end

  assign IO_DataR  = rdat_q;
  assign EIC_I_Req = req_q;
  assign EIC_I_Id  = id_q;

endmodule

// File: tb/tb_external_interrupt_controller.sv
module tb_external_interrupt_controller;

  localparam logic [29:0] BASE = 30'h3FFF_FF00;

  logic        Sys_Clock = 1'b0;
  logic        Sys_Reset = 1'b0;
  logic [1:0]  IRQ_In    = 2'b00;
  logic        IO_EnR    = 1'b0;
  logic        IO_EnW    = 1'b0;
  logic [29:0] IO_Address = '0;
  logic [31:0] IO_DataW  = '0;
  logic [31:0] IO_DataR;
  logic        EIC_I_Req;
  logic        EIC_I_Id;

  external_interrupt_controller #(.BASE_ADDR(BASE)) dut (
    .Sys_Clock  (Sys_Clock),
    .Sys_Reset  (Sys_Reset),
    .IRQ_In     (IRQ_In),
    .IO_EnR     (IO_EnR),
    .IO_EnW     (IO_EnW),
    .IO_Address (IO_Address),
    .IO_DataW   (IO_DataW),
    .IO_DataR   (IO_DataR),
    .EIC_I_Req  (EIC_I_Req),
    .EIC_I_Id   (EIC_I_Id)
  );

  always #5 Sys_Clock = ~Sys_Clock;

  typedef struct packed {
    logic        req;
    logic        id;
    logic [31:0] dr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: register contents plus a log of IRQ_In per clock since
  // reset release. A level seen at edge k reaches the pending logic at k+2.
  bit [1:0] irq_log[$];
  bit [1:0] m_pend, m_en, m_mode;
  bit       m_gie;
  int       cyc;
  bit [1:0] irq_v;

  function automatic bit [1:0] irq_at(int k);
    if (k < 0 || k >= irq_log.size()) return 2'b00;
    return irq_log[k];
  endfunction

  function automatic bit [31:0] model_read(bit [2:0] off);
    case (off)
      3'd0:    return {30'b0, m_pend};
      3'd1:    return {m_gie, 29'b0, m_en};
      3'd3:    return {30'b0, m_mode};
      default: return 32'b0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the expected outputs after the next rising edge
  // are pushed for the monitor.
  task automatic step(input bit rst, input bit [1:0] irq, input bit enr,
                      input bit enw, input bit hit, input bit [2:0] off,
                      input bit [31:0] dat);
    exp_t e;
    bit [1:0] lv, pv, np;
    bit [1:0] eff;
    @(negedge Sys_Clock);
    Sys_Reset  = rst;
    IRQ_In     = irq;
    IO_EnR     = enr;
    IO_EnW     = enw;
    IO_Address = hit ? {BASE[29:3], off} : {BASE[29:3] ^ 27'h5, off};
    IO_DataW   = dat;
    if (!rst) begin
      irq_log.delete();
      m_pend = 0; m_en = 0; m_mode = 0; m_gie = 0; cyc = 0;
      e = '0;
    end else begin
      irq_log.push_back(irq);
      e.dr  = (enr && hit) ? model_read(off) : 32'b0;
      eff   = m_pend & m_en & {2{m_gie}};
      e.req = (eff != 0);
      e.id  = (eff == 2'b10);
      lv = irq_at(cyc - 2);
      pv = irq_at(cyc - 3);
      np = m_pend;
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i]) np[i] = lv[i];
        else if ((lv[i] && !pv[i]) || (enw && hit && off == 3'd4 && dat[i])) np[i] = 1'b1;
        else if (enw && hit && off == 3'd2 && dat[i]) np[i] = 1'b0;
      end
      m_pend = np;
      if (enw && hit && off == 3'd1) begin m_en = dat[1:0]; m_gie = dat[31]; end
      if (enw && hit && off == 3'd3) m_mode = dat[1:0];
      cyc++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(int n = 1);
    for (int i = 0; i < n; i++) step(1'b1, irq_v, 1'b0, 1'b0, 1'b1, 3'd0, 32'b0);
  endtask

  task automatic wr(bit [2:0] off, bit [31:0] dat);
    step(1'b1, irq_v, 1'b0, 1'b1, 1'b1, off, dat);
  endtask

  task automatic rd(bit [2:0] off, bit hit = 1'b1);
    step(1'b1, irq_v, 1'b1, 1'b0, hit, off, 32'b0);
  endtask

  // Monitor: outputs are presented every clock; compare once per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Sys_Clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("req",  {31'b0, EIC_I_Req}, {31'b0, e.req});
        check("id",   {31'b0, EIC_I_Id},  {31'b0, e.id});
        check("rdata", IO_DataR, e.dr);
      end
    end
  end

  initial begin
    irq_v = 2'b00;
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 32'b0);

    // Edge path: single-cycle pulse on source 0.
    wr(3'd1, 32'h8000_0001);
    irq_v = 2'b01; idle();
    irq_v = 2'b00; idle(4);
    rd(3'd0); idle();

    // Priority: source 1 then source 0, then clear in turn.
    wr(3'd2, 32'h3);
    wr(3'd1, 32'h8000_0003);
    irq_v = 2'b10; idle(4);
    irq_v = 2'b11; idle(4);
    irq_v = 2'b00;
    wr(3'd2, 32'h1); idle();
    wr(3'd2, 32'h2); idle(2);

    // Masking with GIE off, then enabling only source 1.
    wr(3'd1, 32'h0000_0003);
    irq_v = 2'b11; idle();
    irq_v = 2'b00; idle(4);
    wr(3'd1, 32'h8000_0002); idle(2);

    // CLEAR colliding with a new rising edge on source 0.
    wr(3'd2, 32'h3);
    wr(3'd1, 32'h8000_0001); idle(2);
    irq_v = 2'b01; idle();
    irq_v = 2'b00; idle();
    wr(3'd2, 32'h1); idle(3);
    wr(3'd2, 32'h1); idle();

    // Level mode on source 1.
    wr(3'd3, 32'h2);
    wr(3'd1, 32'h8000_0002);
    irq_v = 2'b10; idle(4);
    wr(3'd2, 32'h2); idle(2);
    irq_v = 2'b00; idle(4);
    wr(3'd3, 32'h0);

    // Read every offset, a non-hit read, and a read+write in one cycle.
    wr(3'd1, 32'h8000_0003);
    wr(3'd4, 32'h3);
    for (int o = 0; o < 8; o++) rd(3'(o));
    rd(3'd1, 1'b0);
    step(1'b1, irq_v, 1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_0001);
    rd(3'd1); idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit [2:0] op;
      if ($urandom_range(0, 3) == 0) irq_v = irq_v ^ 2'($urandom_range(0, 3));
      op = 3'($urandom_range(0, 7));
      step(1'b1, irq_v, op[0], op[1] & op[2], $urandom_range(0, 7) != 0,
           3'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset while a request is asserted.
    irq_v = 2'b00;
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h8000_0001);
    wr(3'd4, 32'h1); idle(2);
    rd(3'd1);
    @(posedge Sys_Clock);
    #3;
    Sys_Reset = 1'b0;
    #1;
    check("async_req",   {31'b0, EIC_I_Req}, 32'b0);
    check("async_id",    {31'b0, EIC_I_Id},  32'b0);
    check("async_rdata", IO_DataR, 32'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 32'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 32'b0);
    // Line already high at release counts as an edge.
    irq_v = 2'b01;
    wr(3'd1, 32'h8000_0001);
    idle(5);
    rd(3'd0); rd(3'd1); idle();

    @(posedge Sys_Clock);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
